// File: rtl/sdram_arbiter_if.sv
// Request/response bundle shared by the two requesters, the arbiter and the SDRAM controller.
// The arbiter connects through the slave modport; the environment drives through master.
interface sdram_arbiter_if;
    logic        p0_valid;
    logic [24:0] p0_addr;
    logic [31:0] p0_wdata;
    logic [3:0]  p0_wmask;
    logic [31:0] p0_rdata;
    logic        p0_ready;

    logic        p1_valid;
    logic [24:0] p1_addr;
    logic [31:0] p1_wdata;
    logic [3:0]  p1_wmask;
    logic [31:0] p1_rdata;
    logic        p1_ready;

    logic [24:0] mem_addr;
    logic [31:0] mem_din;
    logic [3:0]  mem_wmask;
    logic        mem_valid;
    logic [31:0] mem_dout;
    logic        mem_busy;
    logic        mem_initialized;

    modport slave (
        input  p0_valid, p0_addr, p0_wdata, p0_wmask,
        output p0_rdata, p0_ready,
        input  p1_valid, p1_addr, p1_wdata, p1_wmask,
        output p1_rdata, p1_ready,
        output mem_addr, mem_din, mem_wmask, mem_valid,
        input  mem_dout, mem_busy, mem_initialized
    );

    modport master (
        output p0_valid, p0_addr, p0_wdata, p0_wmask,
        input  p0_rdata, p0_ready,
        output p1_valid, p1_addr, p1_wdata, p1_wmask,
        input  p1_rdata, p1_ready,
        input  mem_addr, mem_din, mem_wmask, mem_valid,
        output mem_dout, mem_busy, mem_initialized
    );
endinterface

// File: rtl/sdram_arbiter.sv
// Two-port arbiter in front of an SDRAM controller, with issue timeout and retry.
// Define SDRAM_ARB_ROUND_ROBIN_EN for round-robin ties; otherwise port 0 has fixed priority.
module sdram_arbiter #(
    parameter int ISSUE_TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           resetn,
    sdram_arbiter_if.slave bus
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ISSUE   = 3'd1;
    localparam logic [2:0] S_RETRY   = 3'd2;
    localparam logic [2:0] S_WAIT    = 3'd3;
    localparam logic [2:0] S_RESPOND = 3'd4;
    localparam logic [2:0] S_HOLD    = 3'd5;

    localparam int              CNT_W    = $clog2(ISSUE_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ISSUE_TIMEOUT - 1);

    logic [2:0]       state;
    logic             grant;
    logic [CNT_W-1:0] issue_cnt;
    logic             tie;
    logic             any_req;
    logic             grant_nxt;
    logic             take;

    assign tie     = bus.p0_valid & bus.p1_valid;
    assign any_req = bus.p0_valid | bus.p1_valid;
    assign take    = (state == S_IDLE) & bus.mem_initialized & any_req;

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    logic last_grant;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            last_grant <= 1'b1;
        else if (take)
            last_grant <= grant_nxt;
    end

    assign grant_nxt = tie ? ~last_grant : bus.p1_valid;
`else
    assign grant_nxt = tie ? 1'b0 : bus.p1_valid;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= S_IDLE;
            grant         <= 1'b0;
            issue_cnt     <= '0;
            bus.mem_valid <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_din   <= '0;
            bus.mem_wmask <= '0;
            bus.p0_ready  <= 1'b0;
            bus.p1_ready  <= 1'b0;
            bus.p0_rdata  <= '0;
            bus.p1_rdata  <= '0;
        end else begin
            bus.p0_ready <= 1'b0;
            bus.p1_ready <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (take) begin
                        grant         <= grant_nxt;
                        bus.mem_addr  <= grant_nxt ? bus.p1_addr  : bus.p0_addr;
                        bus.mem_din   <= grant_nxt ? bus.p1_wdata : bus.p0_wdata;
                        bus.mem_wmask <= grant_nxt ? bus.p1_wmask : bus.p0_wmask;
                        bus.mem_valid <= 1'b1;
                        issue_cnt     <= '0;
                        state         <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (bus.mem_busy) begin
                        bus.mem_valid <= 1'b0;
                        issue_cnt     <= '0;
                        state         <= S_WAIT;
                    end else if (issue_cnt == CNT_LAST) begin
                        // Controller never acknowledged: drop the strobe for one cycle and reissue
                        bus.mem_valid <= 1'b0;
                        issue_cnt     <= '0;
                        state         <= S_RETRY;
                    end else begin
                        issue_cnt <= issue_cnt + 1'b1;
                    end
                end
                S_RETRY: begin
                    bus.mem_valid <= 1'b1;
                    state         <= S_ISSUE;
                end
                S_WAIT: begin
                    if (!bus.mem_busy) begin
                        if (grant) bus.p1_ready <= 1'b1;
                        else       bus.p0_ready <= 1'b1;
                        if (bus.mem_wmask == 4'd0) begin
                            if (grant) bus.p1_rdata <= bus.mem_dout;
                            else       bus.p0_rdata <= bus.mem_dout;
                        end
                        state <= S_RESPOND;
                    end
                end
                S_RESPOND: state <= S_HOLD;
                S_HOLD:    state <= S_IDLE;
                default:   state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: directed vector table, multi-cycle corner sequences and a
// randomized two-port run scored against a word-level memory model.
`timescale 1ns/1ps
module tb_sdram_arbiter;
    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    sdram_arbiter_if bus ();
    sdram_arbiter #(.ISSUE_TIMEOUT(64)) dut (.clk(clk), .resetn(resetn), .bus(bus));

    // Requester-side drive
    logic        pv [2];
    logic [24:0] pa [2];
    logic [31:0] pw [2];
    logic [3:0]  pm [2];
    logic        init_r;

    assign bus.p0_valid = pv[0];
    assign bus.p0_addr  = pa[0];
    assign bus.p0_wdata = pw[0];
    assign bus.p0_wmask = pm[0];
    assign bus.p1_valid = pv[1];
    assign bus.p1_addr  = pa[1];
    assign bus.p1_wdata = pw[1];
    assign bus.p1_wmask = pm[1];
    assign bus.mem_initialized = init_r;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (m[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // Controller model: registers busy one cycle after accepting a strobe
    bit   [31:0] cmem [256];
    int          busy_left = 0;
    int          fall_cnt = 0;
    logic        prev_mv = 1'b0;
    logic [31:0] ctrl_dout = '0;
    int          busy_len;
    int          ignore_target;

    assign bus.mem_busy = (busy_left != 0);
    assign bus.mem_dout = ctrl_dout;

    always @(posedge clk) begin
        prev_mv <= bus.mem_valid;
        if (prev_mv && !bus.mem_valid) fall_cnt <= fall_cnt + 1;
        if (busy_left > 0) begin
            busy_left <= busy_left - 1;
        end else if (bus.mem_valid && fall_cnt >= ignore_target) begin
            busy_left <= (busy_len > 0) ? busy_len : int'($urandom_range(4, 1));
            ctrl_dout <= cmem[bus.mem_addr[9:2]];
            if (bus.mem_wmask != 4'd0)
                cmem[bus.mem_addr[9:2]] <= merge(cmem[bus.mem_addr[9:2]], bus.mem_din, bus.mem_wmask);
        end
    end

    // Reference model and bookkeeping
    bit   [31:0] ref_mem [256];
    int          checks = 0;
    int          errors = 0;
    int          rdy_cnt [2];
    int          grant_log [$];
    int          rem [2];
    int          gap [2];
    bit          rnd_fields;
    bit          rnd_gap;

    typedef struct {
        int          port;
        logic [24:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        int          busy;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expire(input string name);
        checks++;
        errors++;
        $display("FAIL %s: cycle budget expired at %0t", name, $time);
    endtask

    function automatic logic rdy(input int p);
        return (p == 1) ? bus.p1_ready : bus.p0_ready;
    endfunction

    function automatic logic [31:0] rd(input int p);
        return (p == 1) ? bus.p1_rdata : bus.p0_rdata;
    endfunction

    task automatic new_fields(input int p);
        pa[p] = 25'h100 + 25'(4 * $urandom_range(3, 0));
        pw[p] = $urandom;
        pm[p] = ($urandom_range(1, 0) == 0) ? 4'd0 : 4'($urandom_range(15, 1));
    endtask

    task automatic drive();
        for (int p = 0; p < 2; p++) begin
            if (pv[p] && rdy(p)) begin
                pv[p]  = 1'b0;
                rem[p] = rem[p] - 1;
                gap[p] = rnd_gap ? int'($urandom_range(3, 0)) : 0;
            end else if (!pv[p] && rem[p] > 0) begin
                if (gap[p] > 0) gap[p] = gap[p] - 1;
                else begin
                    if (rnd_fields) new_fields(p);
                    pv[p] = 1'b1;
                end
            end
        end
    endtask

    // One clock: sample on the falling edge, score any completion, then update requesters
    task automatic step();
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            if (rdy(p)) begin
                rdy_cnt[p]++;
                grant_log.push_back(p);
                chk("single_ready", 32'(bus.p0_ready & bus.p1_ready), 32'd0);
                chk("ready_on_valid", 32'(pv[p]), 32'd1);
                chk("mem_addr", 32'(bus.mem_addr), 32'(pa[p]));
                chk("mem_din", bus.mem_din, pw[p]);
                chk("mem_wmask", 32'(bus.mem_wmask), 32'(pm[p]));
                if (pm[p] == 4'd0) chk("rdata", rd(p), ref_mem[pa[p][9:2]]);
                else ref_mem[pa[p][9:2]] = merge(ref_mem[pa[p][9:2]], pw[p], pm[p]);
            end
        end
        drive();
    endtask

    task automatic wait_cnt(input int t0, input int t1, input int budget, input string name);
        int n;
        n = 0;
        while ((rdy_cnt[0] < t0 || rdy_cnt[1] < t1) && n < budget) begin
            step();
            n++;
        end
        if (rdy_cnt[0] < t0 || rdy_cnt[1] < t1) expire(name);
    endtask

    task automatic wait_ctrl_idle();
        int n;
        n = 0;
        while (bus.mem_busy && n < 100) begin
            step();
            n++;
        end
        if (bus.mem_busy) expire("ctrl_idle");
    endtask

    int          b0, b1, hi1, lo, ph, bad_v, bad_r, glen;
    logic [31:0] exp_rd [2];
    int          exp_g;

    initial begin
        vecs[0] = '{0, 25'h0000100,  32'hDEADBEEF, 4'hF, 1, 32'h0};
        vecs[1] = '{1, 25'h0000100,  32'h0,        4'h0, 3, 32'hDEADBEEF};
        vecs[2] = '{1, 25'h0000104,  32'h12345678, 4'h3, 2, 32'h0};
        vecs[3] = '{0, 25'h0000104,  32'h0,        4'h0, 5, 32'h00005678};
        vecs[4] = '{0, 25'h0000104,  32'hAABBCCDD, 4'hC, 1, 32'h0};
        vecs[5] = '{1, 25'h0000104,  32'h0,        4'h0, 4, 32'hAABB5678};
        vecs[6] = '{0, 25'h0000200,  32'h0,        4'h0, 2, 32'h00000000};
        vecs[7] = '{1, 25'h1FFFFFC,  32'hFFFFFFFF, 4'h1, 1, 32'h0};
        vecs[8] = '{0, 25'h1FFFFFC,  32'h0,        4'h0, 3, 32'h000000FF};
        vecs[9] = '{0, 25'h0000100,  32'h0,        4'h0, 6, 32'hDEADBEEF};

        for (int p = 0; p < 2; p++) begin
            pv[p] = 1'b0; pa[p] = '0; pw[p] = '0; pm[p] = '0;
            rem[p] = 0; gap[p] = 0; rdy_cnt[p] = 0; exp_rd[p] = '0;
        end
        init_r = 1'b0; busy_len = 3; ignore_target = 0;
        rnd_fields = 1'b0; rnd_gap = 1'b0;
        resetn = 1'b0;
        repeat (3) step();

        chk("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
        chk("rst_ready", 32'({bus.p0_ready, bus.p1_ready}), 32'd0);
        chk("rst_rdata0", bus.p0_rdata, 32'd0);
        chk("rst_rdata1", bus.p1_rdata, 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_mem_din", bus.mem_din, 32'd0);
        chk("rst_mem_wmask", 32'(bus.mem_wmask), 32'd0);
        resetn = 1'b1;
        step();

        // Controller not initialised: a held write must be ignored
        pa[0] = 25'h0000300; pw[0] = 32'h11223344; pm[0] = 4'hF; rem[0] = 1;
        bad_v = 0; bad_r = 0;
        repeat (20) begin
            step();
            if (bus.mem_valid) bad_v++;
            if (bus.p0_ready) bad_r++;
        end
        chk("uninit_mem_valid", 32'(bad_v), 32'd0);
        chk("uninit_ready", 32'(bad_r), 32'd0);
        init_r = 1'b1;
        wait_cnt(1, 0, 100, "uninit_release");
        step(); step();

        // Directed vector table, one port at a time
        for (int i = 0; i < 10; i++) begin
            int p;
            p = vecs[i].port;
            busy_len = vecs[i].busy;
            pa[p] = vecs[i].addr; pw[p] = vecs[i].wdata; pm[p] = vecs[i].wmask;
            rem[p] = 1; gap[p] = 0;
            b0 = rdy_cnt[0]; b1 = rdy_cnt[1];
            wait_cnt(b0 + (p == 0 ? 1 : 0), b1 + (p == 1 ? 1 : 0), 200, $sformatf("vec%0d", i));
            step(); step(); step();
            if (vecs[i].wmask == 4'd0) exp_rd[p] = vecs[i].exp_rdata;
            chk($sformatf("vec%0d_ready_p0", i), 32'(rdy_cnt[0] - b0), 32'(p == 0 ? 1 : 0));
            chk($sformatf("vec%0d_ready_p1", i), 32'(rdy_cnt[1] - b1), 32'(p == 1 ? 1 : 0));
            chk($sformatf("vec%0d_rdata", i), rd(p), exp_rd[p]);
        end

        // Controller ignores the first strobe: 64 issue cycles, one low cycle, reissue
        busy_len = 2;
        ignore_target = fall_cnt + 1;
        pa[0] = 25'h0000100; pw[0] = '0; pm[0] = 4'h0; rem[0] = 1;
        b0 = rdy_cnt[0]; hi1 = 0; lo = 0; ph = 0;
        for (int n = 0; n < 400 && rdy_cnt[0] == b0; n++) begin
            step();
            if (ph == 0) begin
                if (bus.mem_valid) hi1++;
                else if (hi1 > 0) begin ph = 1; lo = 1; end
            end else if (ph == 1) begin
                if (bus.mem_valid) ph = 2;
                else lo++;
            end
        end
        if (rdy_cnt[0] == b0) expire("timeout_completion");
        step(); step();
        chk("timeout_issue_cycles", 32'(hi1), 32'd64);
        chk("timeout_retry_gap", 32'(lo), 32'd1);
        chk("timeout_ready_count", 32'(rdy_cnt[0] - b0), 32'd1);
        chk("timeout_rdata", bus.p0_rdata, 32'hDEADBEEF);

        // Reset while waiting on the controller: transaction is dropped
        busy_len = 10;
        pa[1] = 25'h0000100; pw[1] = '0; pm[1] = 4'h0; rem[1] = 1;
        b0 = rdy_cnt[0]; b1 = rdy_cnt[1];
        begin
            int n;
            n = 0;
            while (!(bus.mem_busy && !bus.mem_valid) && n < 50) begin step(); n++; end
            if (!(bus.mem_busy && !bus.mem_valid)) expire("reach_wait_done");
        end
        resetn = 1'b0;
        #1;
        chk("rst_wait_mem_valid", 32'(bus.mem_valid), 32'd0);
        chk("rst_wait_rdata1", bus.p1_rdata, 32'd0);
        pv[1] = 1'b0; rem[1] = 0;
        step(); step();
        resetn = 1'b1;
        repeat (15) step();
        chk("rst_wait_no_ready", 32'(rdy_cnt[0] - b0 + rdy_cnt[1] - b1), 32'd0);

        // Reset while issuing: the strobe must fall without a clock edge
        wait_ctrl_idle();
        busy_len = 2;
        ignore_target = fall_cnt + 1;
        pa[0] = 25'h0000104; pw[0] = '0; pm[0] = 4'h0; rem[0] = 1;
        b0 = rdy_cnt[0];
        repeat (6) step();
        chk("issue_mem_valid_high", 32'(bus.mem_valid), 32'd1);
        resetn = 1'b0;
        #1;
        chk("rst_issue_mem_valid", 32'(bus.mem_valid), 32'd0);
        pv[0] = 1'b0; rem[0] = 0;
        step();
        resetn = 1'b1;
        repeat (3) step();
        chk("rst_issue_no_ready", 32'(rdy_cnt[0] - b0), 32'd0);

        // Service resumes normally after reset
        pa[0] = 25'h0000108; pw[0] = 32'hCAFEF00D; pm[0] = 4'hF; rem[0] = 1;
        wait_cnt(b0 + 1, rdy_cnt[1], 100, "post_reset_write");
        step(); step();
        pa[1] = 25'h0000108; pw[1] = '0; pm[1] = 4'h0; rem[1] = 1;
        b1 = rdy_cnt[1];
        wait_cnt(rdy_cnt[0], b1 + 1, 100, "post_reset_read");
        step(); step();
        chk("post_reset_rdata", bus.p1_rdata, 32'hCAFEF00D);

        // Both ports contending, each re-requesting immediately
        wait_ctrl_idle();
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        step();
        busy_len = 0; rnd_fields = 1'b1; rnd_gap = 1'b0;
        glen = grant_log.size();
        b0 = rdy_cnt[0]; b1 = rdy_cnt[1];
        rem[0] = 4; rem[1] = 4;
        wait_cnt(b0 + 4, b1 + 4, 600, "tie_run");
        for (int i = 0; i < 8; i++) begin
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
            exp_g = i % 2;
`else
            exp_g = (i < 4) ? 0 : 1;
`endif
            if (glen + i < grant_log.size())
                chk($sformatf("tie_grant%0d", i), 32'(grant_log[glen + i]), 32'(exp_g));
            else
                expire($sformatf("tie_grant%0d", i));
        end

        // Randomized traffic on both ports with random gaps and busy lengths
        step(); step();
        rnd_gap = 1'b1;
        b0 = rdy_cnt[0]; b1 = rdy_cnt[1];
        rem[0] = 25; rem[1] = 25;
        wait_cnt(b0 + 25, b1 + 25, 3000, "random_run");
        repeat (4) step();
        chk("random_count_p0", 32'(rdy_cnt[0] - b0), 32'd25);
        chk("random_count_p1", 32'(rdy_cnt[1] - b1), 32'd25);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameter ISSUE_TIMEOUT, default 64: maximum cycles in ISSUE without observing mem_busy before a retry.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 resetn  in  1  reset, asynchronous and active-low.
REQ-004 pN_valid  in  1  request from port N (N=0,1); held high with its fields stable until pN_ready.
REQ-005 pN_addr  in  25  byte address for port N.
REQ-006 pN_wdata  in  32  write data for port N.
REQ-007 pN_wmask  in  4  byte write enables; 0 = read.
REQ-008 pN_rdata  out  32  read data returned to port N.
REQ-009 pN_ready  out  1  one-cycle completion pulse to port N.
REQ-010 mem_addr  out  25  address to the SDRAM controller.
REQ-011 mem_din  out  32  write data to the controller.
REQ-012 mem_wmask  out  4  write mask to the controller.
REQ-013 mem_valid  out  1  request strobe to the controller.
REQ-014 mem_dout  in  32  read data from the controller.
REQ-015 mem_busy  in  1  controller busy, active high.
REQ-016 mem_initialized  in  1  controller initialisation complete.

Function
REQ-017 States: IDLE, ISSUE, RETRY, WAIT_DONE, RESPOND, HOLD.
REQ-018 IDLE: if mem_initialized=1 and any pN_valid=1, grant one port, latch its addr/wdata/wmask into mem_addr/mem_din/mem_wmask, set mem_valid=1 and go to ISSUE; otherwise stay in IDLE.
REQ-019 IDLE with mem_initialized=0: all requests ignored, mem_valid stays 0, no ready pulse.
REQ-020 Both ports valid in IDLE: arbitration policy per REQ-034/REQ-035; a lone valid port is always granted.
REQ-021 ISSUE: hold mem_valid=1 and the latched fields; on mem_busy=1, clear mem_valid and go to WAIT_DONE.
REQ-022 ISSUE timeout: after ISSUE_TIMEOUT consecutive ISSUE cycles without mem_busy, go to RETRY with mem_valid=0 for exactly one cycle, then return to ISSUE with mem_valid=1 and the counter cleared.
REQ-023 WAIT_DONE: on the first cycle with mem_busy=0, go to RESPOND.
REQ-024 On entering RESPOND for a read (latched wmask=0), pG_rdata shall equal mem_dout as sampled on that WAIT_DONE cycle; writes leave pG_rdata unchanged.
REQ-025 RESPOND: pG_ready=1 for exactly one cycle on the granted port only, then go to HOLD.
REQ-026 HOLD: one cycle with no grant evaluation, so the requester can drop valid; then go to IDLE.
REQ-027 The non-granted port's valid/fields have no effect until the arbiter returns to IDLE.
REQ-028 mem_addr, mem_din and mem_wmask change only on a grant in IDLE.
REQ-029 Best-case latency is valid-to-ready = 2 cycles plus the controller busy duration.

Reset
REQ-030 On resetn=0: state=IDLE; mem_valid=0, pN_ready=0, pN_rdata=0, mem_addr=0, mem_din=0, mem_wmask=0, timeout counter=0, last_grant=1.
REQ-031 Reset mid-transaction aborts it: no ready pulse for that transaction, and mem_valid=0 immediately (asynchronously).
REQ-032 After resetn deasserts, the first grant obeys REQ-018/REQ-019.

Configuration
REQ-033 Macro SDRAM_ARB_ROUND_ROBIN_EN selects the arbitration policy.
REQ-034 SDRAM_ARB_ROUND_ROBIN_EN defined: on a tie, grant the port not equal to last_grant; last_grant updates on every grant.
REQ-035 SDRAM_ARB_ROUND_ROBIN_EN undefined: fixed priority, port 0 always wins a tie; last_grant logic is not synthesized.

Verification
REQ-036 Cover: mem_initialized=0 with p0 write held 20 cycles -> mem_valid=0 and p0_ready=0 throughout.
REQ-037 Cover: p0 write addr=0x0000100, wdata=0xDEADBEEF, wmask=0xF -> mem_* fields match; one p0_ready pulse; p1_ready stays 0.
REQ-038 Cover: p1 read addr=0x0000100 with the controller model returning 0xDEADBEEF -> p1_rdata=0xDEADBEEF at the p1_ready pulse.
REQ-039 Cover: p0 and p1 valid together for 4 transactions -> with round-robin, grants 0,1,0,1; without it, port 0 is served until it drops valid.
REQ-040 Cover: controller model ignores the first request (no busy for 64 cycles) -> one-cycle mem_valid drop (RETRY), reissue, then completion with one ready pulse.
REQ-041 Cover: resetn asserted during WAIT_DONE -> mem_valid=0 at once, no ready pulse, next request served normally.
